// File: rtl/lane_pkg.sv
// ---------------------------------------------------------------------------
// lane_pkg
// Shared definitions for the lane collector.
//   - state_e   : collector FSM states (IDLE, COLLECT, COMMIT)
//   - LANES     : default number of lanes per word
//   - LANE_W    : width of one lane in bits
//   - LANE_IDLE : value an idle lane presents on the bus
// ---------------------------------------------------------------------------
package lane_pkg;

  localparam int LANES = 4;
  localparam int LANE_W = 4;
  localparam logic [LANE_W-1:0] LANE_IDLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/lane_collector_if.sv
// ---------------------------------------------------------------------------
// lane_collector_if
// Bundles the lane bus from the engine and the consumer read port.
//   din      : lane bus, lane k is din[4k+3:4k]
//   wr       : source write-active, low aborts a partial word
//   lane_en  : per-lane strobe
//   rd       : read request
//   rd_data  : read word
//   rd_valid : one-cycle pulse marking a new rd_data
//   full     : FIFO holds DEPTH words
//   empty    : FIFO holds no words
//   count    : number of stored words
//   err      : sticky protocol error
// Modports: master drives the lane bus and read request, slave is the
// collector itself.
// ---------------------------------------------------------------------------
interface lane_collector_if #(
  parameter int WIDTH = 16,
  parameter int LANES = lane_pkg::LANES,
  parameter int DEPTH = 16
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] din;
  logic             wr;
  logic [LANES-1:0] lane_en;
  logic             rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             err;

  modport master (
    output din, wr, lane_en, rd,
    input  rd_data, rd_valid, full, empty, count, err
  );

  modport slave (
    input  din, wr, lane_en, rd,
    output rd_data, rd_valid, full, empty, count, err
  );

endinterface

// File: rtl/lane_fifo.sv
// ---------------------------------------------------------------------------
// lane_fifo
// DEPTH x WIDTH word store with wrapping write/read pointers, an occupancy
// counter and a registered read port (one-cycle read latency).
//   clk        : clock
//   rst        : asynchronous active-low reset
//   wr_en_i    : write request (ignored when full)
//   wr_data_i  : word to store
//   rd_i       : read request (ignored when empty)
//   rd_data_o  : last word read, holds between reads
//   rd_valid_o : high for one cycle after a successful read
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : stored words
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module lane_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             doWrite;
  logic             doRead;

  // Full and empty come from the registered count only, so a read in the
  // same cycle cannot open room for a write that cycle.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doWrite = wr_en_i && !full_o;
  assign doRead  = rd_i && !empty_o;

  // Storage array is not reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= doRead;
      if (doWrite) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (doRead) begin
        rptr_q    <= rptr_q + 1'b1;
        rd_data_q <= mem[rptr_q];
      end
      // Simultaneous write and read leaves the count unchanged.
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;

endmodule

// File: rtl/lane_collector.sv
// ---------------------------------------------------------------------------
// lane_collector
// Captures a WIDTH-bit word one LANE_W-bit lane at a time, each lane
// qualified by its own strobe, and commits complete words into lane_fifo.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-low reset
//   bus : lane_collector_if.slave (lane bus in, FIFO read port out)
// Optional feature macro: LANE_COLLECTOR_ERR_EN
//   defined   : duplicate strobes keep the first nibble and set a sticky err,
//               strobes while waiting to commit also set err
//   undefined : duplicate strobes overwrite (last wins), err stays 0
// ---------------------------------------------------------------------------
module lane_collector #(
  parameter int WIDTH = 16,
  parameter int LANES = lane_pkg::LANES,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  lane_collector_if.slave  bus
);

  import lane_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES-1:0] take;
  logic             err_q, err_d;
  logic             commitEn;
  logic             fifoFull;

  // Next-state logic: lane capture, abort, and the commit handshake with
  // the FIFO. The mask including this cycle's captures decides whether the
  // word is complete, so all lanes arriving together go straight to COMMIT.
  always_comb begin
    state_d  = state_q;
    asm_d    = asm_q;
    mask_d   = mask_q;
    err_d    = err_q;
    take     = '0;
    commitEn = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (!bus.wr) begin
          mask_d  = '0;
          state_d = IDLE;
        end else begin
`ifdef LANE_COLLECTOR_ERR_EN
          take = bus.lane_en & ~mask_q;
          if (|(bus.lane_en & mask_q)) begin
            err_d = 1'b1;
          end
`else
          take = bus.lane_en;
`endif
          for (int k = 0; k < LANES; k++) begin
            if (take[k]) begin
              asm_d[k*LANE_W +: LANE_W] = bus.din[k*LANE_W +: LANE_W];
            end
          end
          mask_d = mask_q | take;
          if (&mask_d) begin
            state_d = COMMIT;
          end else if (|mask_d) begin
            state_d = COLLECT;
          end
        end
      end
      COMMIT: begin
`ifdef LANE_COLLECTOR_ERR_EN
        if (|bus.lane_en) begin
          err_d = 1'b1;
        end
`endif
        // Stall here until the registered count shows room.
        if (!fifoFull) begin
          commitEn = 1'b1;
          mask_d   = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        mask_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      asm_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (commitEn),
    .wr_data_i  (asm_q),
    .rd_i       (bus.rd),
    .rd_data_o  (bus.rd_data),
    .rd_valid_o (bus.rd_valid),
    .full_o     (fifoFull),
    .empty_o    (bus.empty),
    .count_o    (bus.count)
  );

  assign bus.full = fifoFull;
  assign bus.err  = err_q;

endmodule
